// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register dump reader.
//   - Scan FSM state enumeration.
//   - Field widths for register index, byte lane, byte and assembled word.
//   - Width of the settle counter (enough for SETTLE_CYCLES up to 15).
package reg_dump_reader_pkg;

  localparam int unsigned REG_IDX_W    = 5;
  localparam int unsigned LANE_W       = 2;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned SETTLE_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    EMIT,
    FINISH
  } state_t;

endpackage

// File: rtl/reg_dump_reader_byte_assembler.sv
// byte_assembler: 32-bit word register built from four byte lanes.
// Ports:
//   CLK, reset  - clock, synchronous active-high reset (clears word)
//   clear       - synchronous clear of the whole word
//   wr_en       - write byte_in into the lane selected by lane
//   lane        - byte lane select (0 = bits 7:0 ... 3 = bits 31:24)
//   byte_in     - byte to insert
//   word        - assembled word
module byte_assembler
  import reg_dump_reader_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [LANE_W-1:0] lane,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word
);

  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      word <= '0;
    end else if (wr_en) begin
      word[BYTE_W*lane +: BYTE_W] <= byte_in;
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a range of processor registers through the byte-wide
// debug port, assembling each register into a 32-bit word and handing it out
// over a valid/ready interface.
// Ports:
//   CLK, reset          - clock, synchronous active-high reset
//   start               - begin a scan (only honoured when idle)
//   first_reg, last_reg - inclusive register range, captured on start;
//                         the range wraps 31 -> 0
//   user_addr, reg_bits - register / byte-lane select to the processor
//   register_out_user   - byte returned by the processor
//   dump_valid/ready    - word handshake; dump_data/dump_reg hold the word
//   busy                - scan in progress (through the done cycle)
//   done                - one-cycle pulse after the last word is accepted
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [REG_IDX_W-1:0] first_reg,
  input  logic [REG_IDX_W-1:0] last_reg,
  output logic [REG_IDX_W-1:0] user_addr,
  output logic [LANE_W-1:0]    reg_bits,
  input  logic [BYTE_W-1:0]    register_out_user,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [WORD_W-1:0]    dump_data,
  output logic [REG_IDX_W-1:0] dump_reg,
  output logic                 busy,
  output logic                 done
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [LANE_W-1:0]       LAST_LANE   = '1;

  state_t                  state;
  state_t                  state_nxt;
  logic [REG_IDX_W-1:0]    last_q;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic                    settle_done;
  logic                    accept;
  logic                    last_word;
  logic                    asm_clear;
  logic                    asm_wr;

  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign accept      = (state == EMIT) && dump_ready;
  assign last_word   = (user_addr == last_q);
  assign asm_clear   = (state == IDLE) && start;
  assign asm_wr      = (state == SAMPLE);

  assign dump_valid  = (state == EMIT);
  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (reg_bits == LAST_LANE) ? EMIT : SETTLE;
      EMIT:    if (accept) state_nxt = last_word ? FINISH : SETTLE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Select lines and dump_reg only move on the transitions that leave a
  // state, so they are frozen for the whole of SETTLE and EMIT.
  always_ff @(posedge CLK) begin
    if (reset) begin
      user_addr  <= '0;
      reg_bits   <= '0;
      last_q     <= '0;
      settle_cnt <= '0;
      dump_reg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            user_addr  <= first_reg;
            last_q     <= last_reg;
            reg_bits   <= '0;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_done ? '0 : settle_cnt + 1'b1;
        end
        SAMPLE: begin
          if (reg_bits == LAST_LANE) begin
            dump_reg <= user_addr;
          end else begin
            reg_bits <= reg_bits + 1'b1;
          end
        end
        EMIT: begin
          if (accept && !last_word) begin
            user_addr <= user_addr + 1'b1;
            reg_bits  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  byte_assembler u_asm (
    .CLK     (CLK),
    .reset   (reset),
    .clear   (asm_clear),
    .wr_en   (asm_wr),
    .lane    (reg_bits),
    .byte_in (register_out_user),
    .word    (dump_data)
  );

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

  localparam int unsigned S = 1;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  user_addr;
  logic [1:0]  reg_bits;
  logic [7:0]  register_out_user;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [4:0]  dump_reg;
  logic        busy;
  logic        done;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;
  int unsigned scans    = 0;
  bit          done_due = 0;
  bit          mon_en   = 0;

  // Processor debug port model: the byte is only correct once the select
  // lines have been stable for SETTLE cycles; earlier it returns garbage.
  int unsigned stable = 0;
  logic [6:0]  prev_sel = '0;
  logic [31:0] proc_word;
  logic [7:0]  proc_byte;

  reg_dump_reader #(.SETTLE_CYCLES(S)) dut (
    .CLK               (CLK),
    .reset             (reset),
    .start             (start),
    .first_reg         (first_reg),
    .last_reg          (last_reg),
    .user_addr         (user_addr),
    .reg_bits          (reg_bits),
    .register_out_user (register_out_user),
    .dump_valid        (dump_valid),
    .dump_ready        (dump_ready),
    .dump_data         (dump_data),
    .dump_reg          (dump_reg),
    .busy              (busy),
    .done              (done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] model_word(input logic [4:0] r);
    return 32'hA500_0000 | (32'(r) * 32'h0101_0101);
  endfunction

  always @(negedge CLK) begin
    if ({user_addr, reg_bits} != prev_sel) stable <= 0;
    else if (stable < 255) stable <= stable + 1;
    prev_sel <= {user_addr, reg_bits};
  end

  always_comb begin
    proc_word = model_word(user_addr);
    proc_byte = proc_word[8*reg_bits +: 8];
    register_out_user = (stable >= S) ? proc_byte : ~proc_byte;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
  endtask

  // Monitor: pops the scoreboard on every accepted word; tracks done.
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en && !reset) begin
      if (done || done_due) check("done_pulse", 32'(done), 32'(done_due));
      if (done) done_cnt++;
      done_due = 0;
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(dump_reg), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("dump_reg", 32'(dump_reg), 32'(e.r));
          check("dump_data", dump_data, e.d);
          if (e.last) done_due = 1;
        end
      end
    end else begin
      done_due = 0;
    end
  end

  task automatic push_range(input logic [4:0] f, input logic [4:0] l);
    int unsigned n;
    logic [4:0]  r;
    n = ((l - f) & 31) + 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = 5'(f + i);
      exp_q.push_back('{r, model_word(r), (i == n - 1)});
    end
    scans++;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned k = 0;
    bit seen = 0;
    while (!seen && k < budget) begin
      @(negedge CLK);
      check("busy_in_scan", 32'(busy), 32'd1);
      if (done) seen = 1;
      k++;
    end
    if (!seen) fail_now("wait_done");
    @(negedge CLK);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic run_scan(input logic [4:0] f, input logic [4:0] l,
                          input bit rnd_ready, input bit poke_start);
    int unsigned n, budget, k;
    bit seen;
    n = ((l - f) & 31) + 1;
    budget = n * 60 + 100;
    push_range(f, l);
    @(posedge CLK); #1;
    first_reg = f; last_reg = l; start = 1;
    dump_ready = rnd_ready ? 1'($urandom) : 1'b1;
    @(posedge CLK); #1;
    start = 0; first_reg = 5'($urandom); last_reg = 5'($urandom);
    seen = 0; k = 0;
    while (!seen && k < budget) begin
      @(negedge CLK);
      check("busy_in_scan", 32'(busy), 32'd1);
      if (done) seen = 1;
      if (!seen) begin
        @(posedge CLK); #1;
        if (rnd_ready) dump_ready = 1'($urandom);
        start = poke_start && ($urandom_range(0, 3) == 0);
        if (poke_start) begin
          first_reg = 5'($urandom); last_reg = 5'($urandom);
        end
      end
      k++;
    end
    start = 0;
    if (!seen) fail_now("scan_done");
    @(negedge CLK);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_user_addr"}, 32'(user_addr), 32'd0);
    check({tag, "_reg_bits"}, 32'(reg_bits), 32'd0);
    check({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
    check({tag, "_dump_data"}, dump_data, 32'd0);
    check({tag, "_dump_reg"}, 32'(dump_reg), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, k;
    logic [4:0] f, l;

    reset = 1; start = 0; first_reg = '0; last_reg = '0; dump_ready = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    reset = 0;
    mon_en = 1;

    // Single register with latency measurement.
    push_range(5'd3, 5'd3);
    @(posedge CLK); #1;
    first_reg = 5'd3; last_reg = 5'd3; dump_ready = 1; start = 1; c0 = cyc;
    @(posedge CLK); #1;
    start = 0;
    k = 0;
    do begin @(negedge CLK); k++; end while (!dump_valid && k < 100);
    if (!dump_valid) fail_now("first_word");
    else check("latency", cyc - c0, 4 * (S + 1) + 1);
    wait_done(20);

    // Wrapping range.
    run_scan(5'd30, 5'd1, 1'b0, 1'b0);

    // Backpressure on the first word.
    push_range(5'd5, 5'd6);
    @(posedge CLK); #1;
    first_reg = 5'd5; last_reg = 5'd6; dump_ready = 0; start = 1;
    @(posedge CLK); #1;
    start = 0; first_reg = 5'd9; last_reg = 5'd9;
    k = 0;
    do begin @(negedge CLK); k++; end while (!dump_valid && k < 100);
    if (!dump_valid) fail_now("stall_word");
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge CLK);
      check("stall_valid", 32'(dump_valid), 32'd1);
      check("stall_data", dump_data, model_word(5'd5));
      check("stall_addr", 32'(user_addr), 32'd5);
    end
    @(posedge CLK); #1;
    dump_ready = 1;
    wait_done(100);

    // Full sweep with start pokes during the scan.
    run_scan(5'd0, 5'd31, 1'b0, 1'b1);

    // Reset during SETTLE of register 2 lane 2, together with a start.
    @(posedge CLK); #1;
    first_reg = 5'd2; last_reg = 5'd4; dump_ready = 1; start = 1;
    @(posedge CLK); #1;
    start = 0;
    k = 0;
    do begin @(negedge CLK); k++; end
    while (!(user_addr == 5'd2 && reg_bits == 2'd2) && k < 100);
    if (!(user_addr == 5'd2 && reg_bits == 2'd2)) fail_now("reach_lane2");
    reset = 1; start = 1; first_reg = 5'd7; last_reg = 5'd7;
    @(posedge CLK); #1;
    reset = 0; start = 0;
    @(negedge CLK);
    check_reset_outputs("midscan");
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("idle_after_reset", 32'(busy), 32'd0);
    end
    run_scan(5'd2, 5'd2, 1'b0, 1'b0);

    // Randomized ranges with random backpressure.
    for (int i = 0; i < 6; i++) begin
      f = 5'($urandom);
      l = 5'(f + $urandom_range(0, 5));
      run_scan(f, l, 1'b1, 1'b1);
    end

    repeat (5) @(negedge CLK);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", done_cnt, scans);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
